usb_dev_rw_responder: RTL and testbench

- Device-side responder for the host read/write transaction sequence.
- Read sequence: OUT token, OUT data carrying the 16-bit mempage, IN token, then the device returns 64-bit data.
- Write sequence: OUT token, mempage data, OUT token, 64-bit data.
- Sits between the device protocol layer (decoded packets in, handshake/data packets out) and the device page memory.

---
 rtl/usb_dev_rw_responder_if.sv | 46 ++++
 rtl/usb_dev_rw_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_usb_dev_rw_responder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_dev_rw_responder_if.sv
// ---------------------------------------------------------------------------
// usb_dev_rw_responder_if
//   Bundle of every non-clock signal around the read/write responder.
//   Message port   : msg_valid, msg_type[2:0], msg_data[63:0], msg_crc_ok
//   Response port  : resp_valid, resp_type[1:0], resp_data[63:0], resp_ready
//   Memory port    : mem_addr[15:0], mem_wdata[63:0], mem_we, mem_re,
//                    mem_rdata[63:0], mem_rvalid
//   Status pulses  : read_served, write_served, txn_abort
//   Modports: slave = responder view, master = protocol layer / memory view.
// ---------------------------------------------------------------------------
interface usb_dev_rw_responder_if;
   logic        msg_valid;
   logic [2:0]  msg_type;
   logic [63:0] msg_data;
   logic        msg_crc_ok;

   logic        resp_valid;
   logic [1:0]  resp_type;
   logic [63:0] resp_data;
   logic        resp_ready;

   logic [15:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [63:0] mem_rdata;
   logic        mem_rvalid;

   logic        read_served;
   logic        write_served;
   logic        txn_abort;

   modport slave (
      input  msg_valid, msg_type, msg_data, msg_crc_ok, resp_ready,
             mem_rdata, mem_rvalid,
      output resp_valid, resp_type, resp_data, mem_addr, mem_wdata,
             mem_we, mem_re, read_served, write_served, txn_abort
   );

   modport master (
      output msg_valid, msg_type, msg_data, msg_crc_ok, resp_ready,
             mem_rdata, mem_rvalid,
      input  resp_valid, resp_type, resp_data, mem_addr, mem_wdata,
             mem_we, mem_re, read_served, write_served, txn_abort
   );
endinterface

// File: rtl/usb_dev_rw_responder.sv
// ---------------------------------------------------------------------------
// usb_dev_rw_responder
//   Device-side responder for the host page read/write transaction:
//     read : OUT_TOK, OUT_DATA(mempage), IN_TOK, device returns 64-bit DATA
//     write: OUT_TOK, OUT_DATA(mempage), OUT_TOK, OUT_DATA(64-bit data)
//   Ports:
//     clk     - clock
//     rst     - asynchronous reset, active-high
//     bus_if  - slave view of usb_dev_rw_responder_if (message, response,
//               page memory and status pulse signals)
//   Parameters:
//     TIMEOUT_CYCLES - idle cycles tolerated between packets before abort
//     MAX_RETRY      - read DATA resends allowed before abort
// ---------------------------------------------------------------------------
module usb_dev_rw_responder #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   usb_dev_rw_responder_if.slave bus_if
);
   localparam logic [2:0] MSG_IN_TOK   = 3'b001;
   localparam logic [2:0] MSG_OUT_TOK  = 3'b010;
   localparam logic [2:0] MSG_OUT_DATA = 3'b011;
   localparam logic [2:0] MSG_HS_ACK   = 3'b101;
   localparam logic [2:0] MSG_HS_NAK   = 3'b110;

   localparam logic [1:0] RESP_ACK  = 2'b00;
   localparam logic [1:0] RESP_NAK  = 2'b01;
   localparam logic [1:0] RESP_DATA = 2'b10;

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE, S_GET_PAGE, S_PAGE_HELD, S_RD_WAIT, S_RD_HS, S_WR_DATA
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RTY_W-1:0]  rty_q, rty_d;
   logic [15:0]       addr_q, addr_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [63:0]       rdata_q, rdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic [1:0]        resp_type_q, resp_type_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_re_q, mem_re_d;
   logic              rd_srv_q, rd_srv_d;
   logic              wr_srv_q, wr_srv_d;
   logic              abort_q, abort_d;
   logic              clr;

   // Messages are only looked at while no response is waiting to be taken.
   logic msg_acc, is_in, is_out, is_good, is_bad, is_ack, is_nak, tmo;
   assign msg_acc = bus_if.msg_valid && !resp_valid_q;
   assign is_in   = msg_acc && (bus_if.msg_type == MSG_IN_TOK);
   assign is_out  = msg_acc && (bus_if.msg_type == MSG_OUT_TOK);
   assign is_good = msg_acc && (bus_if.msg_type == MSG_OUT_DATA) &&  bus_if.msg_crc_ok;
   assign is_bad  = msg_acc && (bus_if.msg_type == MSG_OUT_DATA) && !bus_if.msg_crc_ok;
   assign is_ack  = msg_acc && (bus_if.msg_type == MSG_HS_ACK);
   assign is_nak  = msg_acc && (bus_if.msg_type == MSG_HS_NAK);
   // Fires on the cycle that completes TIMEOUT_CYCLES idle cycles.
   assign tmo     = !resp_valid_q && (cnt_q == CNT_LAST);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rty_d        = rty_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      resp_valid_d = resp_valid_q;
      resp_type_d  = resp_type_q;
      mem_we_d     = 1'b0;
      mem_re_d     = 1'b0;
      rd_srv_d     = 1'b0;
      wr_srv_d     = 1'b0;
      abort_d      = 1'b0;
      clr          = 1'b0;

      if (resp_valid_q && bus_if.resp_ready) begin
         resp_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (is_out) begin
               state_d = S_GET_PAGE;
            end else if (is_in) begin
               resp_valid_d = 1'b1;
               resp_type_d  = RESP_NAK;
            end
         end
         S_GET_PAGE: begin
            if (is_good) begin
               addr_d       = bus_if.msg_data[15:0];
               resp_valid_d = 1'b1;
               resp_type_d  = RESP_ACK;
               state_d      = S_PAGE_HELD;
            end else if (is_bad) begin
               resp_valid_d = 1'b1;
               resp_type_d  = RESP_NAK;
               clr          = 1'b1;
            end else if (tmo) begin
               abort_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_PAGE_HELD: begin
            if (is_in) begin
               mem_re_d = 1'b1;
               rty_d    = '0;
               state_d  = S_RD_WAIT;
            end else if (is_out) begin
               state_d = S_WR_DATA;
            end else if (tmo) begin
               abort_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_RD_WAIT: begin
            // The message port is deliberately ignored until memory answers.
            if (bus_if.mem_rvalid) begin
               rdata_d      = bus_if.mem_rdata;
               resp_valid_d = 1'b1;
               resp_type_d  = RESP_DATA;
               state_d      = S_RD_HS;
            end
         end
         S_RD_HS: begin
            if (is_ack) begin
               rd_srv_d = 1'b1;
               state_d  = S_IDLE;
            end else if (is_nak || tmo) begin
               if (rty_q < RTY_MAX) begin
                  // rdata_q still holds the page, so the resend is identical.
                  resp_valid_d = 1'b1;
                  resp_type_d  = RESP_DATA;
                  rty_d        = rty_q + 1'b1;
                  clr          = 1'b1;
               end else begin
                  abort_d = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_WR_DATA: begin
            if (is_good) begin
               wdata_d      = bus_if.msg_data;
               mem_we_d     = 1'b1;
               wr_srv_d     = 1'b1;
               resp_valid_d = 1'b1;
               resp_type_d  = RESP_ACK;
               state_d      = S_IDLE;
            end else if (is_bad) begin
               resp_valid_d = 1'b1;
               resp_type_d  = RESP_NAK;
               clr          = 1'b1;
            end else if (tmo) begin
               abort_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Idle counter: frozen while a response is pending and while memory
      // owns the transaction; never runs in IDLE.
      if ((state_d != state_q) || clr) begin
         cnt_d = '0;
      end else if (!resp_valid_q && (state_q != S_RD_WAIT) && (state_q != S_IDLE)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         rty_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_type_q  <= RESP_ACK;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         rd_srv_q     <= 1'b0;
         wr_srv_q     <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rty_q        <= rty_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         resp_valid_q <= resp_valid_d;
         resp_type_q  <= resp_type_d;
         mem_we_q     <= mem_we_d;
         mem_re_q     <= mem_re_d;
         rd_srv_q     <= rd_srv_d;
         wr_srv_q     <= wr_srv_d;
         abort_q      <= abort_d;
      end
   end

   assign bus_if.resp_valid   = resp_valid_q;
   assign bus_if.resp_type    = resp_type_q;
   assign bus_if.resp_data    = rdata_q;
   assign bus_if.mem_addr     = addr_q;
   assign bus_if.mem_wdata    = wdata_q;
   assign bus_if.mem_we       = mem_we_q;
   assign bus_if.mem_re       = mem_re_q;
   assign bus_if.read_served  = rd_srv_q;
   assign bus_if.write_served = wr_srv_q;
   assign bus_if.txn_abort    = abort_q;
endmodule

// File: tb/tb_usb_dev_rw_responder.sv
// ---------------------------------------------------------------------------
// tb_usb_dev_rw_responder
//   Directed bench for usb_dev_rw_responder: read, write, CRC retry, read
//   retry exhaustion, idle timeout, response backpressure and async reset.
// ---------------------------------------------------------------------------
module tb_usb_dev_rw_responder;
   localparam logic [2:0] IN_TOK   = 3'b001;
   localparam logic [2:0] OUT_TOK  = 3'b010;
   localparam logic [2:0] OUT_DATA = 3'b011;
   localparam logic [2:0] HS_ACK   = 3'b101;
   localparam logic [2:0] HS_NAK   = 3'b110;
   localparam logic [1:0] R_ACK  = 2'b00;
   localparam logic [1:0] R_NAK  = 2'b01;
   localparam logic [1:0] R_DATA = 2'b10;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   n_re = 0, n_we = 0, n_both = 0, n_rd_srv = 0, n_wr_srv = 0;
   int   n_ws_mis = 0, n_abort = 0;

   usb_dev_rw_responder_if bus();

   usb_dev_rw_responder #(
      .TIMEOUT_CYCLES (255),
      .MAX_RETRY      (3)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Strobe monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mem_re) n_re++;
         if (bus.mem_we) n_we++;
         if (bus.mem_re && bus.mem_we) n_both++;
         if (bus.read_served) n_rd_srv++;
         if (bus.write_served) n_wr_srv++;
         if (bus.write_served != bus.mem_we) n_ws_mis++;
         if (bus.txn_abort) n_abort++;
      end
   end

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic send(logic [2:0] t, logic [63:0] d, logic ok);
      bus.msg_valid  = 1'b1;
      bus.msg_type   = t;
      bus.msg_data   = d;
      bus.msg_crc_ok = ok;
      @(negedge clk);
      bus.msg_valid  = 1'b0;
      bus.msg_type   = 3'b000;
      bus.msg_data   = '0;
      bus.msg_crc_ok = 1'b0;
   endtask

   task automatic take_resp(string tag, logic [1:0] et, logic chk_d, logic [63:0] ed);
      int n = 0;
      while (!bus.resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_vld"}, {63'd0, bus.resp_valid}, 64'd1);
      chk({tag, "_type"}, {62'd0, bus.resp_type}, {62'd0, et});
      if (chk_d) chk({tag, "_data"}, bus.resp_data, ed);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk({tag, "_drop"}, {63'd0, bus.resp_valid}, 64'd0);
   endtask

   // Called right after the IN_TOK edge; answers two cycles after mem_re.
   task automatic mem_reply(string tag, logic [15:0] ea, logic [63:0] d);
      chk({tag, "_re"}, {63'd0, bus.mem_re}, 64'd1);
      chk({tag, "_addr"}, {48'd0, bus.mem_addr}, {48'd0, ea});
      @(negedge clk);
      chk({tag, "_re_pulse"}, {63'd0, bus.mem_re}, 64'd0);
      @(negedge clk);
      bus.mem_rdata  = d;
      bus.mem_rvalid = 1'b1;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
   endtask

   // Entered just after the edge that last cleared the idle counter.
   task automatic expect_timeout(string tag);
      int early = 0;
      for (int i = 0; i < 254; i++) begin
         @(negedge clk);
         if (bus.txn_abort) early++;
      end
      chk({tag, "_early"}, 64'(early), 64'd0);
      @(negedge clk);
      chk({tag, "_abort"}, {63'd0, bus.txn_abort}, 64'd1);
      chk({tag, "_noresp"}, {63'd0, bus.resp_valid}, 64'd0);
      @(negedge clk);
      chk({tag, "_pulse"}, {63'd0, bus.txn_abort}, 64'd0);
   endtask

   initial begin
      rst            = 1'b1;
      bus.msg_valid  = 1'b0;
      bus.msg_type   = 3'b000;
      bus.msg_data   = '0;
      bus.msg_crc_ok = 1'b0;
      bus.resp_ready = 1'b0;
      bus.mem_rdata  = '0;
      bus.mem_rvalid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_resp_vld", {63'd0, bus.resp_valid}, 64'd0);
      chk("rst_addr", {48'd0, bus.mem_addr}, 64'd0);
      chk("rst_we_re", {62'd0, bus.mem_we, bus.mem_re}, 64'd0);
      chk("rst_abort", {63'd0, bus.txn_abort}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Read transaction
      send(OUT_TOK, 64'd0, 1'b0);
      send(OUT_DATA, 64'h0000_0000_0000_1234, 1'b1);
      take_resp("rd_page", R_ACK, 1'b0, 64'd0);
      chk("rd_addr", {48'd0, bus.mem_addr}, 64'h1234);
      send(IN_TOK, 64'd0, 1'b0);
      mem_reply("rd_mem", 16'h1234, 64'hDEAD_BEEF_0000_0001);
      take_resp("rd_data", R_DATA, 1'b1, 64'hDEAD_BEEF_0000_0001);
      send(HS_ACK, 64'd0, 1'b0);
      chk("rd_served", {63'd0, bus.read_served}, 64'd1);
      @(negedge clk);
      chk("rd_served_pulse", {63'd0, bus.read_served}, 64'd0);

      // Write transaction
      send(OUT_TOK, 64'd0, 1'b0);
      send(OUT_DATA, 64'h0000_0000_0000_00A5, 1'b1);
      take_resp("wr_page", R_ACK, 1'b0, 64'd0);
      send(OUT_TOK, 64'd0, 1'b0);
      send(OUT_DATA, 64'h0123_4567_89AB_CDEF, 1'b1);
      chk("wr_we", {63'd0, bus.mem_we}, 64'd1);
      chk("wr_served", {63'd0, bus.write_served}, 64'd1);
      chk("wr_addr", {48'd0, bus.mem_addr}, 64'h00A5);
      chk("wr_wdata", bus.mem_wdata, 64'h0123_4567_89AB_CDEF);
      take_resp("wr_data", R_ACK, 1'b0, 64'd0);
      chk("wr_we_pulse", {63'd0, bus.mem_we}, 64'd0);

      // CRC error on the page, then a good resend
      send(OUT_TOK, 64'd0, 1'b0);
      send(OUT_DATA, 64'h0000_0000_0000_0777, 1'b0);
      take_resp("crc_bad", R_NAK, 1'b0, 64'd0);
      chk("crc_addr_kept", {48'd0, bus.mem_addr}, 64'h00A5);
      send(OUT_DATA, 64'h0000_0000_0000_0777, 1'b1);
      take_resp("crc_good", R_ACK, 1'b0, 64'd0);
      chk("crc_addr", {48'd0, bus.mem_addr}, 64'h0777);
      #1;
      chk("crc_no_re", 64'(n_re), 64'd1);
      chk("crc_no_we", 64'(n_we), 64'd1);

      // Read retry exhaustion (page 0x0777 is held, so IN_TOK starts a read)
      @(negedge clk);
      send(IN_TOK, 64'd0, 1'b0);
      mem_reply("rty_mem", 16'h0777, 64'h5555_AAAA_5555_AAAA);
      take_resp("rty_first", R_DATA, 1'b1, 64'h5555_AAAA_5555_AAAA);
      for (int i = 0; i < 4; i++) begin
         send(HS_NAK, 64'd0, 1'b0);
         if (i < 3) begin
            take_resp("rty_resend", R_DATA, 1'b1, 64'h5555_AAAA_5555_AAAA);
         end else begin
            chk("rty_abort", {63'd0, bus.txn_abort}, 64'd1);
            chk("rty_noresp", {63'd0, bus.resp_valid}, 64'd0);
         end
      end
      send(IN_TOK, 64'd0, 1'b0);
      take_resp("rty_idle_nak", R_NAK, 1'b0, 64'd0);
      #1;
      chk("rty_no_served", 64'(n_rd_srv), 64'd1);

      // Idle timeout after OUT_TOK
      @(negedge clk);
      send(OUT_TOK, 64'd0, 1'b0);
      expect_timeout("tmo");
      send(IN_TOK, 64'd0, 1'b0);
      take_resp("tmo_idle_nak", R_NAK, 1'b0, 64'd0);

      // Backpressure: pending NAK held 10 cycles, message during it dropped
      send(OUT_TOK, 64'd0, 1'b0);
      send(OUT_DATA, 64'h0000_0000_0000_0BAD, 1'b0);
      for (int i = 0; i < 10; i++) begin
         chk("bp_vld", {63'd0, bus.resp_valid}, 64'd1);
         chk("bp_type", {62'd0, bus.resp_type}, {62'd0, R_NAK});
         if (i == 4) send(OUT_DATA, 64'h0000_0000_0000_0FFF, 1'b1);
         else @(negedge clk);
      end
      chk("bp_dropped_addr", {48'd0, bus.mem_addr}, 64'h0777);
      take_resp("bp_nak", R_NAK, 1'b0, 64'd0);
      expect_timeout("bp_tmo");

      // Async reset while a DATA resend is pending in RD_HS
      send(OUT_TOK, 64'd0, 1'b0);
      send(OUT_DATA, 64'h0000_0000_0000_0BEE, 1'b1);
      take_resp("rs_page", R_ACK, 1'b0, 64'd0);
      send(IN_TOK, 64'd0, 1'b0);
      mem_reply("rs_mem", 16'h0BEE, 64'hCAFE_F00D_1234_5678);
      take_resp("rs_data", R_DATA, 1'b1, 64'hCAFE_F00D_1234_5678);
      send(HS_NAK, 64'd0, 1'b0);
      chk("rs_pending", {63'd0, bus.resp_valid}, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rs_resp_vld", {63'd0, bus.resp_valid}, 64'd0);
      chk("rs_resp_type", {62'd0, bus.resp_type}, 64'd0);
      chk("rs_resp_data", bus.resp_data, 64'd0);
      chk("rs_addr", {48'd0, bus.mem_addr}, 64'd0);
      chk("rs_wdata", bus.mem_wdata, 64'd0);
      chk("rs_strobes", {59'd0, bus.mem_we, bus.mem_re, bus.read_served,
                         bus.write_served, bus.txn_abort}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(IN_TOK, 64'd0, 1'b0);
      take_resp("rs_idle_nak", R_NAK, 1'b0, 64'd0);

      // Totals over the whole run
      @(negedge clk);
      #1;
      chk("sum_re", 64'(n_re), 64'd3);
      chk("sum_we", 64'(n_we), 64'd1);
      chk("sum_both", 64'(n_both), 64'd0);
      chk("sum_rd_srv", 64'(n_rd_srv), 64'd1);
      chk("sum_wr_srv", 64'(n_wr_srv), 64'd1);
      chk("sum_ws_align", 64'(n_ws_mis), 64'd0);
      chk("sum_abort", 64'(n_abort), 64'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
